// File: rtl/rvh_l1d_req_dec_arb.sv
// L1D request front end: arbitrates load, store/atomic and PTW channels, decodes
// the winner and queues it in a small FIFO toward the L1D pipeline.

package rrv64_l1d_pkg;

  localparam int LDU_OP_WIDTH = 3;
  localparam int STU_OP_WIDTH = 5;

  typedef enum logic [LDU_OP_WIDTH-1:0] {
    LDU_LB, LDU_LH, LDU_LW, LDU_LD, LDU_LBU, LDU_LHU, LDU_LWU
  } ldu_op_t;

  typedef enum logic [STU_OP_WIDTH-1:0] {
    STU_SB, STU_SH, STU_SW, STU_SD,
    STU_LRW, STU_LRD, STU_SCW, STU_SCD,
    STU_AMOSWAPW, STU_AMOADDW, STU_AMOANDW, STU_AMOORW, STU_AMOXORW,
    STU_AMOMAXW, STU_AMOMAXUW, STU_AMOMINW, STU_AMOMINUW,
    STU_AMOSWAPD, STU_AMOADDD, STU_AMOANDD, STU_AMOORD, STU_AMOXORD,
    STU_AMOMAXD, STU_AMOMAXUD, STU_AMOMIND, STU_AMOMINUD
  } stu_op_t;

  typedef enum logic [3:0] {
    AMOSWAP, AMOADD, AMOAND, AMOOR, AMOXOR, AMOMAX, AMOMIN
  } amo_type_t;

  typedef struct packed {
    logic      is_ld;
    logic      is_st;
    logic      is_lr;
    logic      is_sc;
    logic      is_amo;
    logic      is_ptw_ld;
    logic      op_b;
    logic      op_hw;
    logic      op_w;
    logic      op_dw;
    logic      ld_u;
    logic      amo_u;
    amo_type_t amo_type;
  } rrv64_l1d_req_type_dec_t;

endpackage

module rvh_l1d_req_dec_arb
  import rrv64_l1d_pkg::*;
#(
  parameter int N_LD  = 2,
  parameter int N_ST  = 1,
  parameter int TAG_W = 8,
  parameter int DEPTH = 2,
  parameter int SRC_W = $clog2(N_LD + N_ST + 1)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [N_LD-1:0]                          ld_vld_i,
  input  logic [N_LD*LDU_OP_WIDTH-1:0]             ld_opcode_i,
  input  logic [N_LD*TAG_W-1:0]                    ld_tag_i,
  output logic [N_LD-1:0]                          ld_rdy_o,
  input  logic [N_ST-1:0]                          st_vld_i,
  input  logic [N_ST*STU_OP_WIDTH-1:0]             st_opcode_i,
  input  logic [N_ST*TAG_W-1:0]                    st_tag_i,
  output logic [N_ST-1:0]                          st_rdy_o,
  input  logic                                     ptw_vld_i,
  input  logic [TAG_W-1:0]                         ptw_tag_i,
  output logic                                     ptw_rdy_o,
  output logic                                     out_vld_o,
  input  logic                                     out_rdy_i,
  output logic [$bits(rrv64_l1d_req_type_dec_t)-1:0] out_dec_o,
  output logic [SRC_W-1:0]                         out_src_o,
  output logic [TAG_W-1:0]                         out_tag_o,
  output logic                                     illegal_vld_o,
  output logic [SRC_W-1:0]                         illegal_src_o,
  output logic [15:0]                              illegal_cnt_o
);

  localparam int N_RR  = N_LD + N_ST;
  localparam int RR_W  = (N_RR > 1) ? $clog2(N_RR) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    rrv64_l1d_req_type_dec_t dec;
    logic [SRC_W-1:0]        src;
    logic [TAG_W-1:0]        tag;
  } entry_t;

  function automatic rrv64_l1d_req_type_dec_t dec_ld(input logic [LDU_OP_WIDTH-1:0] op);
    rrv64_l1d_req_type_dec_t d;
    d = '0;
    case (op)
      LDU_LB:  begin d.is_ld = 1'b1; d.op_b  = 1'b1; end
      LDU_LH:  begin d.is_ld = 1'b1; d.op_hw = 1'b1; end
      LDU_LW:  begin d.is_ld = 1'b1; d.op_w  = 1'b1; end
      LDU_LD:  begin d.is_ld = 1'b1; d.op_dw = 1'b1; end
      LDU_LBU: begin d.is_ld = 1'b1; d.op_b  = 1'b1; d.ld_u = 1'b1; end
      LDU_LHU: begin d.is_ld = 1'b1; d.op_hw = 1'b1; d.ld_u = 1'b1; end
      LDU_LWU: begin d.is_ld = 1'b1; d.op_w  = 1'b1; d.ld_u = 1'b1; end
      default: ;
    endcase
    return d;
  endfunction

  function automatic rrv64_l1d_req_type_dec_t dec_st(input logic [STU_OP_WIDTH-1:0] op);
    rrv64_l1d_req_type_dec_t d;
    d = '0;
    case (op)
      STU_SB:  begin d.is_st = 1'b1; d.op_b  = 1'b1; end
      STU_SH:  begin d.is_st = 1'b1; d.op_hw = 1'b1; end
      STU_SW:  begin d.is_st = 1'b1; d.op_w  = 1'b1; end
      STU_SD:  begin d.is_st = 1'b1; d.op_dw = 1'b1; end
      STU_LRW: begin d.is_lr = 1'b1; d.op_w  = 1'b1; end
      STU_LRD: begin d.is_lr = 1'b1; d.op_dw = 1'b1; end
      STU_SCW: begin d.is_sc = 1'b1; d.op_w  = 1'b1; end
      STU_SCD: begin d.is_sc = 1'b1; d.op_dw = 1'b1; end
      STU_AMOSWAPW, STU_AMOSWAPD: begin d.is_amo = 1'b1; d.amo_type = AMOSWAP; end
      STU_AMOADDW,  STU_AMOADDD:  begin d.is_amo = 1'b1; d.amo_type = AMOADD;  end
      STU_AMOANDW,  STU_AMOANDD:  begin d.is_amo = 1'b1; d.amo_type = AMOAND;  end
      STU_AMOORW,   STU_AMOORD:   begin d.is_amo = 1'b1; d.amo_type = AMOOR;   end
      STU_AMOXORW,  STU_AMOXORD:  begin d.is_amo = 1'b1; d.amo_type = AMOXOR;  end
      STU_AMOMAXW,  STU_AMOMAXD:  begin d.is_amo = 1'b1; d.amo_type = AMOMAX;  end
      STU_AMOMAXUW, STU_AMOMAXUD: begin d.is_amo = 1'b1; d.amo_type = AMOMAX; d.amo_u = 1'b1; end
      STU_AMOMINW,  STU_AMOMIND:  begin d.is_amo = 1'b1; d.amo_type = AMOMIN;  end
      STU_AMOMINUW, STU_AMOMINUD: begin d.is_amo = 1'b1; d.amo_type = AMOMIN; d.amo_u = 1'b1; end
      default: ;
    endcase
    // Doubleword AMOs occupy the upper half of the AMO opcode range.
    if (d.is_amo) begin
      d.op_dw = (op >= STU_AMOSWAPD);
      d.op_w  = ~d.op_dw;
    end
    return d;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [N_RR-1:0]         rr_req;
  logic [RR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [RR_W-1:0]         grant_id;
  logic                    grant_rr, grant_ptw;
  int                      rr_idx;
  logic                    space, xfer, legal, enq, deq, illegal;
  rrv64_l1d_req_type_dec_t sel_dec;
  logic [SRC_W-1:0]        sel_src;
  logic [TAG_W-1:0]        sel_tag;

  entry_t                  mem_q [DEPTH];
  entry_t                  mem_d [DEPTH];
  entry_t                  head;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    illegal_vld_q, illegal_vld_d;
  logic [SRC_W-1:0]        illegal_src_q, illegal_src_d;
  logic [15:0]             illegal_cnt_q, illegal_cnt_d;

  assign rr_req = {st_vld_i, ld_vld_i};
  assign deq    = out_vld_o & out_rdy_i;
  assign space  = (cnt_q < CNT_W'(DEPTH)) | deq;

  always_comb begin
    grant_ptw = 1'b0;
    grant_rr  = 1'b0;
    grant_id  = '0;
    rr_idx    = 0;
    if (!rst && space) begin
      if (ptw_vld_i) begin
        grant_ptw = 1'b1;
      end else begin
        for (int i = 0; i < N_RR; i++) begin
          rr_idx = int'(rr_ptr_q) + i;
          if (rr_idx >= N_RR) rr_idx = rr_idx - N_RR;
          if (!grant_rr && rr_req[RR_W'(rr_idx)]) begin
            grant_rr = 1'b1;
            grant_id = RR_W'(rr_idx);
          end
        end
      end
    end
  end

  always_comb begin
    ld_rdy_o  = '0;
    st_rdy_o  = '0;
    ptw_rdy_o = grant_ptw;
    for (int i = 0; i < N_LD; i++) ld_rdy_o[i] = grant_rr && (grant_id == RR_W'(i));
    for (int j = 0; j < N_ST; j++) st_rdy_o[j] = grant_rr && (grant_id == RR_W'(N_LD + j));
  end

  // Only the winning channel's opcode and tag reach the decoder.
  always_comb begin
    sel_dec = '0;
    sel_src = '0;
    sel_tag = '0;
    if (grant_ptw) begin
      sel_dec.is_ptw_ld = 1'b1;
      sel_dec.op_dw     = 1'b1;
      sel_src           = SRC_W'(N_RR);
      sel_tag           = ptw_tag_i;
    end else if (grant_rr) begin
      sel_src = SRC_W'(grant_id);
      for (int i = 0; i < N_LD; i++) begin
        if (grant_id == RR_W'(i)) begin
          sel_dec = dec_ld(ld_opcode_i[i*LDU_OP_WIDTH +: LDU_OP_WIDTH]);
          sel_tag = ld_tag_i[i*TAG_W +: TAG_W];
        end
      end
      for (int j = 0; j < N_ST; j++) begin
        if (grant_id == RR_W'(N_LD + j)) begin
          sel_dec = dec_st(st_opcode_i[j*STU_OP_WIDTH +: STU_OP_WIDTH]);
          sel_tag = st_tag_i[j*TAG_W +: TAG_W];
        end
      end
    end
  end

  assign xfer    = grant_ptw | grant_rr;
  assign legal   = sel_dec.is_ld | sel_dec.is_st | sel_dec.is_lr |
                   sel_dec.is_sc | sel_dec.is_amo | sel_dec.is_ptw_ld;
  assign enq     = xfer & legal;
  assign illegal = xfer & ~legal;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(enq) - CNT_W'(deq);
    rr_ptr_d = rr_ptr_q;
    if (enq) begin
      mem_d[wr_ptr_q] = '{dec: sel_dec, src: sel_src, tag: sel_tag};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (deq) rd_ptr_d = ptr_inc(rd_ptr_q);
    // Illegal requests still count as a transfer and advance the pointer.
    if (grant_rr) rr_ptr_d = (grant_id == RR_W'(N_RR - 1)) ? '0 : grant_id + 1'b1;
  end

  always_comb begin
    illegal_vld_d = illegal;
    illegal_src_d = illegal ? sel_src : illegal_src_q;
    illegal_cnt_d = illegal_cnt_q;
    if (illegal && (illegal_cnt_q != 16'hFFFF)) illegal_cnt_d = illegal_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      rr_ptr_q      <= '0;
      illegal_vld_q <= 1'b0;
      illegal_src_q <= '0;
      illegal_cnt_q <= '0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      illegal_vld_q <= illegal_vld_d;
      illegal_src_q <= illegal_src_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign out_vld_o     = (cnt_q != '0);
  assign out_dec_o     = out_vld_o ? head.dec : '0;
  assign out_src_o     = out_vld_o ? head.src : '0;
  assign out_tag_o     = out_vld_o ? head.tag : '0;
  assign illegal_vld_o = illegal_vld_q;
  assign illegal_src_o = illegal_src_q;
  assign illegal_cnt_o = illegal_cnt_q;

endmodule

// File: tb/tb_rvh_l1d_req_dec_arb.sv
// Directed bench for rvh_l1d_req_dec_arb: arbitration order, decode, FIFO
// back-pressure, illegal-opcode reporting and reset behaviour.

module tb_rvh_l1d_req_dec_arb;
  import rrv64_l1d_pkg::*;

  localparam int N_LD  = 2;
  localparam int N_ST  = 1;
  localparam int TAG_W = 8;
  localparam int DEPTH = 2;
  localparam int SRC_W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ld_vld_i, ld_rdy_o;
  logic [5:0]  ld_opcode_i;
  logic [15:0] ld_tag_i;
  logic [0:0]  st_vld_i, st_rdy_o;
  logic [4:0]  st_opcode_i;
  logic [7:0]  st_tag_i;
  logic        ptw_vld_i, ptw_rdy_o;
  logic [7:0]  ptw_tag_i;
  logic        out_vld_o, out_rdy_i;
  logic [15:0] out_dec_o;
  logic [1:0]  out_src_o;
  logic [7:0]  out_tag_o;
  logic        illegal_vld_o;
  logic [1:0]  illegal_src_o;
  logic [15:0] illegal_cnt_o;

  int nCompared   = 0;
  int nMismatched = 0;

  rrv64_l1d_req_type_dec_t eLbu, ePtw, eSd, eAmo, eScd;

  rvh_l1d_req_dec_arb #(
    .N_LD(N_LD), .N_ST(N_ST), .TAG_W(TAG_W), .DEPTH(DEPTH), .SRC_W(SRC_W)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_vld_i(ld_vld_i), .ld_opcode_i(ld_opcode_i), .ld_tag_i(ld_tag_i), .ld_rdy_o(ld_rdy_o),
    .st_vld_i(st_vld_i), .st_opcode_i(st_opcode_i), .st_tag_i(st_tag_i), .st_rdy_o(st_rdy_o),
    .ptw_vld_i(ptw_vld_i), .ptw_tag_i(ptw_tag_i), .ptw_rdy_o(ptw_rdy_o),
    .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i), .out_dec_o(out_dec_o),
    .out_src_o(out_src_o), .out_tag_o(out_tag_o),
    .illegal_vld_o(illegal_vld_o), .illegal_src_o(illegal_src_o), .illegal_cnt_o(illegal_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] ldVld, input logic stVld, input logic ptwVld,
                               input logic outRdy);
    ld_vld_i  = ldVld;
    st_vld_i  = stVld;
    ptw_vld_i = ptwVld;
    out_rdy_i = outRdy;
    #1;
  endtask

  initial begin
    logic [1:0] expSrc [6];
    int         n;
    expSrc = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

    eLbu = '0; eLbu.is_ld = 1'b1; eLbu.op_b = 1'b1; eLbu.ld_u = 1'b1;
    ePtw = '0; ePtw.is_ptw_ld = 1'b1; ePtw.op_dw = 1'b1;
    eSd  = '0; eSd.is_st = 1'b1; eSd.op_dw = 1'b1;
    eAmo = '0; eAmo.is_amo = 1'b1; eAmo.amo_u = 1'b1; eAmo.op_w = 1'b1; eAmo.amo_type = AMOMAX;
    eScd = '0; eScd.is_sc = 1'b1; eScd.op_dw = 1'b1;

    rst = 1'b1;
    ld_opcode_i = '0; ld_tag_i = '0; st_opcode_i = '0; st_tag_i = '0; ptw_tag_i = '0;
    applyStimulus(2'b11, 1'b1, 1'b1, 1'b1);
    stepCycle();
    stepCycle();
    checkOutput("rst_ld_rdy", ld_rdy_o, 0);
    checkOutput("rst_st_rdy", st_rdy_o, 0);
    checkOutput("rst_ptw_rdy", ptw_rdy_o, 0);
    checkOutput("rst_out_vld", out_vld_o, 0);
    checkOutput("rst_out_dec", out_dec_o, 0);
    checkOutput("rst_illegal_vld", illegal_vld_o, 0);
    checkOutput("rst_illegal_cnt", illegal_cnt_o, 0);
    rst = 1'b0;
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);

    // Single LBU load on channel 0.
    ld_opcode_i[0 +: 3] = LDU_LBU;
    ld_tag_i[0 +: 8]    = 8'h12;
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b1);
    checkOutput("lbu_ld_rdy", ld_rdy_o, 2'b01);
    stepCycle();
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
    checkOutput("lbu_out_vld", out_vld_o, 1);
    checkOutput("lbu_out_dec", out_dec_o, eLbu);
    checkOutput("lbu_out_src", out_src_o, 0);
    checkOutput("lbu_out_tag", out_tag_o, 8'h12);
    stepCycle();
    checkOutput("lbu_drained", out_vld_o, 0);

    // Round robin over two loads and one store, starting from a fresh pointer.
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    ld_opcode_i = {LDU_LD, LDU_LW};
    ld_tag_i    = {8'hA1, 8'hA0};
    st_opcode_i = STU_SW;
    st_tag_i    = 8'hA2;
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      checkOutput("rr_ld_rdy", ld_rdy_o, (expSrc[i] == 2'd0) ? 2'b01 : (expSrc[i] == 2'd1) ? 2'b10 : 2'b00);
      checkOutput("rr_st_rdy", st_rdy_o, (expSrc[i] == 2'd2) ? 1 : 0);
      stepCycle();
      checkOutput("rr_out_src", out_src_o, expSrc[i]);
      checkOutput("rr_out_tag", out_tag_o, 8'hA0 + 8'(expSrc[i]));
    end

    // PTW overrides everyone and leaves the pointer alone.
    ptw_tag_i = 8'h5B;
    applyStimulus(2'b11, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("ptw_rdy", ptw_rdy_o, 1);
      checkOutput("ptw_ld_rdy", ld_rdy_o, 0);
      stepCycle();
      checkOutput("ptw_out_src", out_src_o, 3);
      checkOutput("ptw_out_dec", out_dec_o, ePtw);
      checkOutput("ptw_out_tag", out_tag_o, 8'h5B);
    end
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b1);
    checkOutput("post_ptw_ld_rdy", ld_rdy_o, 2'b01);
    stepCycle();
    checkOutput("post_ptw_src", out_src_o, 0);
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
    stepCycle();
    checkOutput("post_ptw_drained", out_vld_o, 0);

    // Back-pressure: two stores fill the FIFO, the third waits for a dequeue.
    st_opcode_i = STU_SD;
    st_tag_i    = 8'h01;
    applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
    checkOutput("sd_st_rdy", st_rdy_o, 1);
    stepCycle();
    st_opcode_i = STU_AMOMAXUW;
    st_tag_i    = 8'h02;
    #1;
    checkOutput("amo_st_rdy", st_rdy_o, 1);
    stepCycle();
    st_opcode_i = STU_SCD;
    st_tag_i    = 8'h03;
    #1;
    checkOutput("full_st_rdy", st_rdy_o, 0);
    checkOutput("full_head_dec", out_dec_o, eSd);
    checkOutput("full_head_src", out_src_o, 2);
    stepCycle();
    checkOutput("stall_st_rdy", st_rdy_o, 0);
    checkOutput("stall_head_tag", out_tag_o, 8'h01);
    checkOutput("stall_head_dec", out_dec_o, eSd);
    applyStimulus(2'b00, 1'b1, 1'b0, 1'b1);
    checkOutput("deq_enq_st_rdy", st_rdy_o, 1);
    stepCycle();
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
    checkOutput("amo_head_vld", out_vld_o, 1);
    checkOutput("amo_head_dec", out_dec_o, eAmo);
    checkOutput("amo_head_tag", out_tag_o, 8'h02);
    stepCycle();
    checkOutput("scd_head_dec", out_dec_o, eScd);
    checkOutput("scd_head_tag", out_tag_o, 8'h03);
    stepCycle();
    checkOutput("stores_drained", out_vld_o, 0);

    // Undefined load opcode on channel 1.
    ld_opcode_i[3 +: 3] = 3'd7;
    applyStimulus(2'b10, 1'b0, 1'b0, 1'b1);
    checkOutput("ill_ld_rdy", ld_rdy_o, 2'b10);
    stepCycle();
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
    checkOutput("ill_vld", illegal_vld_o, 1);
    checkOutput("ill_src", illegal_src_o, 1);
    checkOutput("ill_cnt", illegal_cnt_o, 1);
    checkOutput("ill_not_enq", out_vld_o, 0);
    stepCycle();
    checkOutput("ill_pulse_end", illegal_vld_o, 0);
    checkOutput("ill_cnt_hold", illegal_cnt_o, 1);

    // Fill the FIFO then reset in the middle of it.
    ld_opcode_i[0 +: 3] = LDU_LW;
    ld_tag_i[0 +: 8]    = 8'h31;
    applyStimulus(2'b01, 1'b0, 1'b0, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("fill_out_vld", out_vld_o, 1);
    checkOutput("fill_ld_rdy", ld_rdy_o, 0);
    rst = 1'b1;
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b1);
    checkOutput("midrst_ld_rdy", ld_rdy_o, 0);
    checkOutput("midrst_st_rdy", st_rdy_o, 0);
    stepCycle();
    rst = 1'b0;
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst_out_vld", out_vld_o, 0);
    checkOutput("midrst_out_tag", out_tag_o, 0);
    checkOutput("midrst_ill_cnt", illegal_cnt_o, 0);
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b1);
    checkOutput("midrst_ptr0", ld_rdy_o, 2'b01);
    stepCycle();
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
    stepCycle();

    // Saturate the illegal counter with a continuous stream of bad opcodes.
    applyStimulus(2'b10, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (illegal_cnt_o != 16'hFFFF && n < 70000) begin
      stepCycle();
      n++;
    end
    checkOutput("sat_reached", illegal_cnt_o, 16'hFFFF);
    for (int i = 0; i < 3; i++) stepCycle();
    checkOutput("sat_hold", illegal_cnt_o, 16'hFFFF);
    checkOutput("sat_pulse", illegal_vld_o, 1);
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
